// File: rtl/toy_mem_arb_pkg.sv
// Shared types and defaults for the toy memory arbiter slice.
package toy_mem_arb_pkg;

  localparam int ADDR_WIDTH           = 32;
  localparam int BUS_DATA_WIDTH       = 32;
  localparam int MEM_ARB_NUM_REQ      = 2;
  localparam int MEM_ARB_STARVE_LIMIT = 8;

  // One memory access as seen on the SRAM side of the arbiter.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]       addr;
    logic                        wr_en;
    logic [BUS_DATA_WIDTH-1:0]   wr_data;
    logic [BUS_DATA_WIDTH/8-1:0] wr_byte_en;
  } mem_req_t;

  // Bus lock: either free for normal arbitration or held by one owner.
  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

endpackage

// File: rtl/toy_mem_arb_if.sv
// Requester, response and SRAM signals of the arbiter bundled as one interface.
interface toy_mem_arb_if
  import toy_mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = MEM_ARB_NUM_REQ,
  parameter int ADDR_WIDTH = toy_mem_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
);

  logic [NUM_REQ-1:0]                  req_vld;
  logic [NUM_REQ-1:0]                  req_rdy;
  logic [NUM_REQ-1:0]                  req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr;
  logic [NUM_REQ-1:0]                  req_wr_en;
  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wr_data;
  logic [NUM_REQ*DATA_WIDTH/8-1:0]     req_wr_byte_en;
  logic [NUM_REQ-1:0]                  rsp_vld;
  logic [DATA_WIDTH-1:0]               rsp_rd_data;
  logic                                mem_en;
  logic [ADDR_WIDTH-1:0]               mem_addr;
  logic [DATA_WIDTH-1:0]               mem_wr_data;
  logic [DATA_WIDTH/8-1:0]             mem_wr_byte_en;
  logic                                mem_wr_en;
  logic [DATA_WIDTH-1:0]               mem_rd_data;

  // Requesters plus the SRAM model: they drive requests and read data.
  modport master (
    output req_vld, req_lock, req_addr, req_wr_en, req_wr_data, req_wr_byte_en,
    output mem_rd_data,
    input  req_rdy, rsp_vld, rsp_rd_data,
    input  mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en
  );

  // The arbiter itself.
  modport slave (
    input  req_vld, req_lock, req_addr, req_wr_en, req_wr_data, req_wr_byte_en,
    input  mem_rd_data,
    output req_rdy, rsp_vld, rsp_rd_data,
    output mem_en, mem_addr, mem_wr_data, mem_wr_byte_en, mem_wr_en
  );

endinterface

// File: rtl/toy_prio_arb.sv
// Combinational priority picker: urgent requesters first, then lowest index.
module toy_prio_arb
  import toy_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = MEM_ARB_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [NUM_REQ-1:0] urgent_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] urgentElig;
  logic [NUM_REQ-1:0] pool;

  // Narrow to the urgent class if any, then isolate its lowest set bit.
  always_comb begin
    urgentElig = eligible_i & urgent_i;
    pool       = (urgentElig != '0) ? urgentElig : eligible_i;
    grant_o    = pool & (~pool + NUM_REQ'(1));
  end

endmodule

// File: rtl/toy_mem_arb.sv
// Single-port SRAM arbiter: priority with aging, bus lock, read-data routing.
module toy_mem_arb
  import toy_mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = MEM_ARB_NUM_REQ,
  parameter int ADDR_WIDTH   = toy_mem_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = BUS_DATA_WIDTH,
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  toy_mem_arb_if.slave  bus
);

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam int BE_W    = DATA_WIDTH / 8;

  lock_state_e                     state_q, state_d;
  logic [OWNER_W-1:0]              owner_q, owner_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [NUM_REQ-1:0]              rspVld_q, rspVld_d;

  logic [NUM_REQ-1:0]              eligible;
  logic [NUM_REQ-1:0]              urgent;
  logic [NUM_REQ-1:0]              grant;
  logic [OWNER_W-1:0]              winIdx;
  logic                            memEn;

  // Only valid requesters compete; a held lock shrinks the field to its owner.
  always_comb begin
    eligible = '0;
    urgent   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      urgent[i] = (waitCnt_q[i] == CNT_W'(STARVE_LIMIT));
    end
    if (!rst) begin
      if (state_q == LOCK_HELD) begin
        eligible[owner_q] = bus.req_vld[owner_q];
      end else begin
        eligible = bus.req_vld;
      end
    end
  end

  toy_prio_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_prio_arb (
    .eligible_i (eligible),
    .urgent_i   (urgent),
    .grant_o    (grant)
  );

  // Turn the one-hot grant into an index for muxing and lock ownership.
  always_comb begin
    winIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) winIdx = OWNER_W'(i);
    end
  end

  assign memEn           = |grant;
  assign bus.req_rdy     = grant;
  assign bus.mem_en      = memEn;
  assign bus.rsp_vld     = rspVld_q;
  assign bus.rsp_rd_data = bus.mem_rd_data;

  // Present the winner's access to the SRAM in the grant cycle; zeros when idle.
  always_comb begin
    bus.mem_addr       = '0;
    bus.mem_wr_data    = '0;
    bus.mem_wr_byte_en = '0;
    bus.mem_wr_en      = 1'b0;
    if (memEn) begin
      bus.mem_addr       = bus.req_addr[winIdx*ADDR_WIDTH +: ADDR_WIDTH];
      bus.mem_wr_data    = bus.req_wr_data[winIdx*DATA_WIDTH +: DATA_WIDTH];
      bus.mem_wr_byte_en = bus.req_wr_byte_en[winIdx*BE_W +: BE_W];
      bus.mem_wr_en      = bus.req_wr_en[winIdx];
    end
  end

  // Lock next state: take on a locked grant, release when the owner drops lock.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      LOCK_IDLE: begin
        if (memEn && bus.req_lock[winIdx]) begin
          state_d = LOCK_HELD;
          owner_d = winIdx;
        end
      end
      LOCK_HELD: begin
        if (!bus.req_lock[owner_q]) state_d = LOCK_IDLE;
      end
      default: state_d = LOCK_IDLE;
    endcase
  end

  // Waiting requesters age up to the limit; a grant or a dropped valid clears them.
  always_comb begin
    waitCnt_d = waitCnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!bus.req_vld[i] || grant[i]) begin
        waitCnt_d[i] = '0;
      end else if (!urgent[i]) begin
        waitCnt_d[i] = waitCnt_q[i] + CNT_W'(1);
      end
    end
  end

  // A read granted this cycle owns the SRAM output on the next cycle.
  assign rspVld_d = grant & ~bus.req_wr_en;

  // State, counters and response flags; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOCK_IDLE;
      owner_q   <= '0;
      waitCnt_q <= '0;
      rspVld_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      waitCnt_q <= waitCnt_d;
      rspVld_q  <= rspVld_d;
    end
  end

endmodule

// File: tb/tb_toy_mem_arb.sv
// Self-checking bench for toy_mem_arb: directed scenarios plus random traffic.
module tb_toy_mem_arb;
  import toy_mem_arb_pkg::*;

  localparam int NR  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  toy_mem_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  toy_mem_arb #(
    .NUM_REQ      (NR),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM environment: 256 words indexed by the low address byte, 1-cycle read.
  logic [DW-1:0] memArray [256];
  logic [DW-1:0] memRdData;
  assign bus.mem_rd_data = memRdData;

  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_wr_en) begin
        for (int b = 0; b < BW; b++) begin
          if (bus.mem_wr_byte_en[b]) memArray[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wr_data[b*8 +: 8];
        end
      end else begin
        memRdData <= memArray[bus.mem_addr[7:0]];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
  task automatic applyStimulus(input logic r, input logic [NR-1:0] vld, input logic [NR-1:0] lock,
                               input logic [NR-1:0] wen, input logic [AW-1:0] a0 = '0,
                               input logic [AW-1:0] a1 = '0, input logic [DW-1:0] d0 = '0,
                               input logic [DW-1:0] d1 = '0, input logic [BW-1:0] be0 = '1,
                               input logic [BW-1:0] be1 = '1);
    @(posedge clk);
    #1;
    rst                = r;
    bus.req_vld        = vld;
    bus.req_lock       = lock;
    bus.req_wr_en      = wen;
    bus.req_addr       = {a1, a0};
    bus.req_wr_data    = {d1, d0};
    bus.req_wr_byte_en = {be1, be0};
    @(negedge clk);
  endtask

  // Reference model: arbitration rules expressed on integers and a word array.
  int            mWait [NR];
  bit            mLocked;
  int            mOwner;
  logic [NR-1:0] mRsp;
  logic [DW-1:0] mRspData;
  logic [DW-1:0] refMem [256];
  bit            modelValid = 1'b0;

  always @(negedge clk) begin
    int            win;
    logic [NR-1:0] expRdy;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wbe;
    win = -1;
    if (rst !== 1'b1) begin
      if (mLocked) begin
        if (bus.req_vld[mOwner]) win = mOwner;
      end else begin
        for (int i = 0; i < NR; i++) if (win < 0 && bus.req_vld[i] && mWait[i] == LIM) win = i;
        for (int i = 0; i < NR; i++) if (win < 0 && bus.req_vld[i]) win = i;
      end
    end
    expRdy = '0;
    if (win >= 0) expRdy[win] = 1'b1;
    addr  = (win >= 0) ? bus.req_addr[win*AW +: AW] : '0;
    wdata = (win >= 0) ? bus.req_wr_data[win*DW +: DW] : '0;
    wbe   = (win >= 0) ? bus.req_wr_byte_en[win*BW +: BW] : '0;

    if (modelValid) begin
      checkOutput("req_rdy", 64'(bus.req_rdy), 64'(expRdy));
      checkOutput("mem_en", 64'(bus.mem_en), 64'(win >= 0));
      if (win >= 0) begin
        checkOutput("mem_addr", 64'(bus.mem_addr), 64'(addr));
        checkOutput("mem_wr_en", 64'(bus.mem_wr_en), 64'(bus.req_wr_en[win]));
        if (bus.req_wr_en[win]) begin
          checkOutput("mem_wr_data", 64'(bus.mem_wr_data), 64'(wdata));
          checkOutput("mem_wr_byte_en", 64'(bus.mem_wr_byte_en), 64'(wbe));
        end
      end else begin
        checkOutput("mem_wr_en_idle", 64'(bus.mem_wr_en), 64'(0));
      end
      checkOutput("rsp_vld", 64'(bus.rsp_vld), 64'(mRsp));
      if (mRsp != '0) checkOutput("rsp_rd_data", 64'(bus.rsp_rd_data), 64'(mRspData));
    end

    if (rst === 1'b1) begin
      mLocked    = 1'b0;
      mOwner     = 0;
      mRsp       = '0;
      for (int i = 0; i < NR; i++) mWait[i] = 0;
      modelValid = 1'b1;
    end else begin
      mRsp = '0;
      if (win >= 0) begin
        if (bus.req_wr_en[win]) begin
          for (int b = 0; b < BW; b++) if (wbe[b]) refMem[addr[7:0]][b*8 +: 8] = wdata[b*8 +: 8];
        end else begin
          mRsp[win] = 1'b1;
          mRspData  = refMem[addr[7:0]];
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!bus.req_vld[i] || i == win) mWait[i] = 0;
        else if (mWait[i] < LIM) mWait[i] = mWait[i] + 1;
      end
      if (!mLocked) begin
        if (win >= 0 && bus.req_lock[win]) begin
          mLocked = 1'b1;
          mOwner  = win;
        end
      end else if (!bus.req_lock[mOwner]) begin
        mLocked = 1'b0;
      end
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    int req1Grants;
    rst                = 1'b1;
    bus.req_vld        = '0;
    bus.req_lock       = '0;
    bus.req_wr_en      = '0;
    bus.req_addr       = '0;
    bus.req_wr_data    = '0;
    bus.req_wr_byte_en = '0;
    for (int i = 0; i < 256; i++) begin
      memArray[i] = $urandom;
      refMem[i]   = memArray[i];
    end
    memArray[8'h40] = 32'hDEADBEEF;
    refMem[8'h40]   = 32'hDEADBEEF;

    applyStimulus(1'b1, 2'b11, 2'b00, 2'b00);
    checkOutput("reset_rdy", 64'(bus.req_rdy), 64'(0));
    checkOutput("reset_mem_en", 64'(bus.mem_en), 64'(0));

    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h40);
    checkOutput("rd_rdy", 64'(bus.req_rdy), 64'(2'b10));
    checkOutput("rd_mem_en", 64'(bus.mem_en), 64'(1));
    checkOutput("rd_mem_addr", 64'(bus.mem_addr), 64'(32'h40));
    checkOutput("post_reset_rsp", 64'(bus.rsp_vld), 64'(0));

    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
    checkOutput("rd_rsp_vld", 64'(bus.rsp_vld), 64'(2'b10));
    checkOutput("rd_rsp_data", 64'(bus.rsp_rd_data), 64'(32'hDEADBEEF));

    applyStimulus(1'b0, 2'b01, 2'b00, 2'b01, 32'h10, 32'h0, 32'h12345678, 32'h0, 4'b0011, 4'hF);
    checkOutput("wr_rdy", 64'(bus.req_rdy), 64'(2'b01));
    checkOutput("wr_mem_wr_en", 64'(bus.mem_wr_en), 64'(1));
    checkOutput("wr_byte_en", 64'(bus.mem_wr_byte_en), 64'(4'b0011));
    checkOutput("wr_data", 64'(bus.mem_wr_data), 64'(32'h12345678));

    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
    checkOutput("wr_no_rsp", 64'(bus.rsp_vld), 64'(0));

    req1Grants = 0;
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b0, 2'b11, 2'b00, 2'b00, 32'h20, 32'h24);
      if (bus.req_rdy[1]) req1Grants++;
      if (k == 7) checkOutput("starve_req0_8th", 64'(bus.req_rdy), 64'(2'b01));
      if (k == 8 || k == 17) checkOutput("starve_req1_turn", 64'(bus.req_rdy), 64'(2'b10));
    end
    checkOutput("starve_req1_count", 64'(req1Grants), 64'(2));
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);

    applyStimulus(1'b0, 2'b10, 2'b10, 2'b00, 32'h20, 32'h40);
    checkOutput("lock_take", 64'(bus.req_rdy), 64'(2'b10));
    applyStimulus(1'b0, 2'b11, 2'b10, 2'b00, 32'h20, 32'h44);
    checkOutput("lock_hold_rd", 64'(bus.req_rdy), 64'(2'b10));
    applyStimulus(1'b0, 2'b11, 2'b10, 2'b10, 32'h20, 32'h48, 32'h0, 32'hCAFE0001);
    checkOutput("lock_hold_wr", 64'(bus.req_rdy), 64'(2'b10));
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 2'b01, 2'b10, 2'b00, 32'h20, 32'h0);
      if (k == 7) checkOutput("lock_blocks_urgent", 64'(bus.req_rdy), 64'(2'b00));
    end
    applyStimulus(1'b0, 2'b11, 2'b00, 2'b10, 32'h20, 32'h4C, 32'h0, 32'hA5A5A5A5);
    checkOutput("lock_release_xfer", 64'(bus.req_rdy), 64'(2'b10));
    applyStimulus(1'b0, 2'b01, 2'b00, 2'b00, 32'h20);
    checkOutput("after_release", 64'(bus.req_rdy), 64'(2'b01));
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);

    applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 32'h30, 32'h34);
    checkOutput("simul_first", 64'(bus.req_rdy), 64'(2'b01));
    applyStimulus(1'b0, 2'b11, 2'b11, 2'b00, 32'h30, 32'h34);
    checkOutput("simul_req0_owns", 64'(bus.req_rdy), 64'(2'b01));
    applyStimulus(1'b0, 2'b11, 2'b10, 2'b00, 32'h30, 32'h34);
    checkOutput("simul_req0_release", 64'(bus.req_rdy), 64'(2'b01));
    applyStimulus(1'b0, 2'b10, 2'b10, 2'b00, 32'h30, 32'h34);
    checkOutput("simul_req1_after", 64'(bus.req_rdy), 64'(2'b10));
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);

    applyStimulus(1'b0, 2'b01, 2'b01, 2'b00, 32'h50);
    checkOutput("rstlock_take", 64'(bus.req_rdy), 64'(2'b01));
    applyStimulus(1'b1, 2'b11, 2'b01, 2'b00, 32'h50, 32'h54);
    checkOutput("rstlock_rdy", 64'(bus.req_rdy), 64'(2'b00));
    checkOutput("rstlock_mem_en", 64'(bus.mem_en), 64'(0));
    applyStimulus(1'b0, 2'b10, 2'b00, 2'b00, 32'h50, 32'h54);
    checkOutput("rstlock_req1", 64'(bus.req_rdy), 64'(2'b10));
    checkOutput("rstlock_rsp_drop", 64'(bus.rsp_vld), 64'(0));

    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    NR'($urandom),
                    {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
                    NR'($urandom),
                    32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                    $urandom, $urandom, BW'($urandom), BW'($urandom));
    end
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_mem_arb.md
Name: toy_mem_arb

Overview:
- Shares one single-port synchronous SRAM (en/addr/wr_data/wr_byte_en/wr_en/rd_data, 1-cycle read latency) between NUM_REQ requesters, e.g. core LSU (req 0) and a debug/DMA master (req 1).
- Fixed priority, lowest index wins, with per-requester anti-starvation aging.
- Optional bus lock for atomic read-modify-write sequences.
- Routes read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- STARVE_LIMIT, 8, wait cycles before a requester becomes urgent (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_vld  in  NUM_REQ  request valid, one bit per requester.
- req_rdy  out  NUM_REQ  grant; transfer occurs when vld&rdy.
- req_lock  in  NUM_REQ  request or hold an exclusive lock.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses.
- req_wr_en  in  NUM_REQ  1 = write, 0 = read.
- req_wr_data  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_wr_byte_en  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- rsp_vld  out  NUM_REQ  read data valid for requester i.
- rsp_rd_data  out  DATA_WIDTH  shared read data; qualified by rsp_vld.
- mem_en  out  1  memory access enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wr_data  out  DATA_WIDTH  memory write data.
- mem_wr_byte_en  out  DATA_WIDTH/8  memory byte enables.
- mem_wr_en  out  1  memory write enable.
- mem_rd_data  in  DATA_WIDTH  memory read data, valid 1 cycle after a read with mem_en.

Behaviour:
- One clock; reset synchronous active-high. Under rst: state=IDLE, all wait counters=0, rsp_vld=0. req_rdy and mem_en are combinational and are 0 while rst=1.
- Grant (combinational, same cycle):
  - Only requesters with req_vld=1 are eligible.
  - Urgent (wait_cnt==STARVE_LIMIT) eligible requesters outrank non-urgent ones. Within each class, lowest index wins.
  - At most one req_rdy bit is set (one-hot or zero).
- Memory drive:
  - mem_en = |(req_vld&req_rdy). mem_addr/wr_data/wr_byte_en/wr_en are muxed from the winner.
  - When idle, mem_en=0, mem_wr_en=0, and the other mem outputs are don't-care (drive 0).
  - No added latency: the memory samples the access at the same edge.
- Response:
  - rsp_vld[i] is registered: 1 in the cycle after a read grant to i; writes produce no response.
  - rsp_rd_data = mem_rd_data (pass-through).
  - Back-to-back reads are allowed; one read is in flight per cycle.
- Wait counters, per requester:
  - Increment when vld=1 and not granted; saturate at STARVE_LIMIT.
  - Clear when granted or when vld=0.
- Lock FSM, states IDLE and LOCKED(owner):
  - IDLE -> LOCKED(i): on a granted transfer of i with req_lock[i]=1.
  - LOCKED(i): only i is eligible; all other req_rdy=0 (their counters keep aging, saturated). i is granted whenever req_vld[i]=1, regardless of urgency elsewhere.
  - LOCKED(i) -> IDLE: in any cycle with req_lock[i]=0, sampled even without vld. A transfer by i in that cycle is still granted. Arbitration is normal from the next cycle.
  - An urgent requester cannot break a lock.
  - Simultaneous lock requests from several requesters: only the winner locks.
- Reset mid-lock or mid-read: returns to IDLE, and a pending rsp_vld is dropped (0 next cycle).

Decomposition:
- toy_pack gains: typedef mem_req_t {addr, wr_en, wr_data, wr_byte_en} sized by ADDR_WIDTH/BUS_DATA_WIDTH; localparam MEM_ARB_NUM_REQ=2; localparam MEM_ARB_STARVE_LIMIT=8.
- Sub-module toy_prio_arb holds the combinational priority picker (urgent mask, then eligible mask, then lowest-set one-hot). It is instantiated once; the FSM, counters and response pipe stay in toy_mem_arb.

Test Plan:
- Single read: req1 vld, addr 0x40, mem holds 0xDEADBEEF -> same cycle req_rdy=2'b10, mem_en=1, mem_addr=0x40; next cycle rsp_vld=2'b10, rsp_rd_data=0xDEADBEEF.
- Contention: both vld every cycle, STARVE_LIMIT=8 -> req0 granted 8 cycles, req1 granted on cycle 9, counters reset, pattern repeats (1 in 9 to req1).
- Write no response: req0 write addr 0x10, data 0x12345678, byte_en 4'b0011 -> mem_wr_en=1, mem_wr_byte_en=4'b0011; rsp_vld stays 0.
- Lock: req1 read with lock=1, req0 vld continuously; req1 holds lock 3 cycles with a write in cycle 3, then lock=0 -> req0 rdy=0 during the lock even when urgent; req0 granted the cycle after lock drops.
- Simultaneous: both vld in the same cycle with lock=1 -> only req0 granted and locked; req1 waits.
- Reset mid-lock with an outstanding read: rst=1 for 1 cycle -> rsp_vld=0, state IDLE, counters 0; req1 is granted immediately after rst deasserts.
